// File: rtl/channel_fifo_pkg.sv
// Shared router sizing: payload/address split of a flit, port count and
// the receive-buffer depth used when the router top builds its FIFOs.
package channel_fifo_pkg;

  localparam int unsigned PAYLOAD_SIZE = 8;
  localparam int unsigned ADDR_BITS    = 4;
  localparam int unsigned DIRECTIONS   = 5;
  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned ITEM_WIDTH   = PAYLOAD_SIZE + ADDR_BITS;

  typedef enum logic [2:0] {
    DIR_N = 3'd0,
    DIR_E = 3'd1,
    DIR_S = 3'd2,
    DIR_W = 3'd3,
    DIR_L = 3'd4
  } dir_e;

  typedef struct packed {
    logic [PAYLOAD_SIZE-1:0] payload;
    logic [ADDR_BITS-1:0]    addr;
  } item_t;

  // Destination field of a flit; the routing table indexes on this.
  function automatic logic [ADDR_BITS-1:0] item_addr(input item_t it);
    return it.addr;
  endfunction

endpackage

// File: rtl/channel_fifo.sv
// Per-direction first-word-fall-through receive buffer feeding the routing stage.
// The head item is presented combinationally so routing lookup and pop share a cycle.
module channel_fifo
  import channel_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = ITEM_WIDTH,
  parameter int unsigned DEPTH    = FIFO_DEPTH,
  parameter int unsigned PTR_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    item_in,
  input  logic                ena,
  output logic                busy,
  output logic [WIDTH-1:0]    item_out,
  output logic                empty,
  input  logic                read,
  output logic [PTR_BITS:0]   count,
  output logic                overflow
);

  localparam int unsigned CNT_BITS = PTR_BITS + 1;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [PTR_BITS-1:0] r_wr_ptr;
  logic [PTR_BITS-1:0] r_rd_ptr;
  logic [CNT_BITS-1:0] r_count;
  logic                r_overflow;

  logic                w_wr;
  logic                w_rd;
  logic                w_empty;
  logic                w_full;
  logic [CNT_BITS-1:0] w_count_nxt;

  // Flow-control flags come from the registered count only.
  assign w_empty = (r_count == CNT_BITS'(0));
  assign w_full  = (r_count == CNT_BITS'(DEPTH));
  assign w_wr    = ena & ~w_full;
  assign w_rd    = read & ~w_empty;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + CNT_BITS'(1);
      2'b01:   w_count_nxt = r_count - CNT_BITS'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
      r_count <= w_count_nxt;
      // Sticky: a flit offered while full is lost for good.
      if (ena && w_full) r_overflow <= 1'b1;
    end
  end

  // Storage needs no reset; stale entries are never visible past the pointers.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= item_in;
  end

  assign item_out = w_empty ? '0 : r_mem[r_rd_ptr];
  assign empty    = w_empty;
  assign busy     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_channel_fifo.sv
// Directed-vector bench for channel_fifo with hand-computed expectations.
module tb_channel_fifo;
  import channel_fifo_pkg::*;

  localparam int unsigned W = ITEM_WIDTH;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] item_in;
  logic         ena;
  logic         busy;
  logic [W-1:0] item_out;
  logic         empty;
  logic         read;
  logic [2:0]   count;
  logic         overflow;

  int n_vec = 0;
  int n_err = 0;

  channel_fifo dut (
    .clk      (clk),
    .reset    (reset),
    .item_in  (item_in),
    .ena      (ena),
    .busy     (busy),
    .item_out (item_out),
    .empty    (empty),
    .read     (read),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    ena = 1'b1; item_in = v; read = 1'b0;
    step();
    ena = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [W-1:0] exp);
    check(tag, 32'(item_out), 32'(exp));
    read = 1'b1; ena = 1'b0;
    step();
    read = 1'b0;
  endtask

  initial begin
    reset = 1'b0; ena = 1'b1; read = 1'b0; item_in = W'(12'h07A);
    #1;
    step(); step();
    reset = 1'b1; ena = 1'b0;
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_item", 32'(item_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Fill to full
    for (int i = 0; i < 4; i++) begin
      ena = 1'b1; item_in = W'((i + 1) * 32'h11);
      step();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_head", 32'(item_out), 32'h11);
      check("fill_busy", 32'(busy), (i == 3) ? 32'd1 : 32'd0);
    end
    ena = 1'b0;

    // Drain in order
    for (int i = 0; i < 4; i++) pop_check("drain", W'((i + 1) * 32'h11));
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_count", 32'(count), 32'd0);

    // Read while empty is ignored
    read = 1'b1;
    step();
    read = 1'b0;
    check("rd_empty_count", 32'(count), 32'd0);
    check("rd_empty_ovf", 32'(overflow), 32'd0);

    // Streaming across pointer wrap at occupancy 2
    push(W'(12'h001));
    push(W'(12'h002));
    for (int i = 0; i < 10; i++) begin
      check("stream_head", 32'(item_out), 32'(i + 1));
      ena = 1'b1; read = 1'b1; item_in = W'(32'(i + 3));
      step();
      check("stream_count", 32'(count), 32'd2);
    end
    ena = 1'b0; read = 1'b0;
    check("stream_ovf", 32'(overflow), 32'd0);
    pop_check("stream_tail0", W'(12'h00B));
    pop_check("stream_tail1", W'(12'h00C));
    check("stream_empty", 32'(empty), 32'd1);

    // Overflow while full
    for (int i = 0; i < 4; i++) push(W'(32'hA1 + 32'(i)));
    push(W'(12'h055));
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) pop_check("ovf_drain", W'(32'hA1 + 32'(i)));
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_empty", 32'(empty), 32'd1);

    // Empty with read and ena together
    ena = 1'b1; read = 1'b1; item_in = W'(12'h066);
    step();
    ena = 1'b0; read = 1'b0;
    check("er_count", 32'(count), 32'd1);
    check("er_item", 32'(item_out), 32'h66);
    check("er_empty", 32'(empty), 32'd0);
    pop_check("er_pop", W'(12'h066));

    // Reset mid-stream clears overflow and contents
    push(W'(12'h0D1));
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_item", 32'(item_out), 32'd0);

    // Full with read and ena together: pop happens, write is dropped
    for (int i = 0; i < 4; i++) push(W'(32'hB1 + 32'(i)));
    ena = 1'b1; read = 1'b1; item_in = W'(12'h0CC);
    step();
    ena = 1'b0; read = 1'b0;
    check("fr_count", 32'(count), 32'd3);
    check("fr_ovf", 32'(overflow), 32'd1);
    check("fr_busy", 32'(busy), 32'd0);
    for (int i = 1; i < 4; i++) pop_check("fr_drain", W'(32'hB1 + 32'(i)));
    check("fr_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/channel_fifo.md
Name: channel_fifo

Overview:
- Per-direction receive buffer placed directly upstream of the router's routing/arbitration stage; one instance per port (N, E, S, W, L).
- Write side is the link from the neighbouring router's output channel (ena/busy/item). Read side feeds the routing stage (item/empty/read).
- First-word-fall-through FIFO: head item and its address field are visible combinationally whenever not empty, so the routing table lookup happens in the same cycle as the read.

Parameters:
- WIDTH, `PAYLOAD_SIZE+`ADDR_BITS, item width; address occupies bits [`ADDR_BITS-1:0].
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- PTR_BITS, 2, log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- item_in  in  WIDTH  item from the upstream link.
- ena  in  1  write strobe from upstream; one item per cycle.
- busy  out  1  full indication to upstream.
- item_out  out  WIDTH  head item to the routing stage.
- empty  out  1  no item available.
- read  in  1  pop strobe from the routing stage.
- count  out  PTR_BITS+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset (reset==0 at clk edge): wr_ptr=0, rd_ptr=0, count=0, overflow=0. Therefore empty=1, busy=0, item_out=0.
- Storage: DEPTH x WIDTH register array. Pointers are PTR_BITS wide and wrap naturally from DEPTH-1 to 0.
- empty = (count==0). busy = (count==DEPTH). Both are derived from registered count only, with no combinational path from ena or read.
- item_out = mem[rd_ptr] when !empty, else all-zero.
- Accepted write: wr = ena & !busy. Writes mem[wr_ptr]<=item_in and advances wr_ptr.
- Accepted read: rd = read & !empty. Advances rd_ptr.
- count next value:
  - count+1 on wr only.
  - count-1 on rd only.
  - unchanged on both or neither.
- Latency: an item written at edge k is visible on item_out with empty=0 after edge k (one cycle), provided it is at the head.
- Full with read and ena in the same cycle: the read pops; the write is dropped because busy was 1. overflow is set, and count ends at DEPTH-1.
- Empty with read and ena in the same cycle: the read is ignored, the write is stored, and count ends at 1. This is not an error.
- Read while empty (without ena) is ignored; no state change, no flag.
- ena while busy: item discarded, overflow<=1. overflow stays set until reset.
- Reset asserted mid-stream discards all stored items; contents of mem are don't-care after reset.
- Sustained throughput: one write and one read per cycle when 0<count<DEPTH.

Decomposition:
- Shared defines header holds `PAYLOAD_SIZE, `ADDR_BITS, `DIRECTIONS, and a new `FIFO_DEPTH (default 4) used by the router top to set DEPTH.
- Flat single module; no sub-module is natural. The storage array is inferred inline.

Test Plan:
- Reset: hold reset=0 for 2 cycles with ena=1 -> empty=1, busy=0, count=0, item_out=0, overflow=0 after release.
- Fill: write 0x11,0x22,0x33,0x44 on consecutive cycles with no reads -> count steps 1..4, busy=1 after 4th edge, item_out=0x11 from cycle after the first write.
- Drain in order: from full, read=1 for 4 cycles -> item_out sequence 0x11,0x22,0x33,0x44, then empty=1, count=0.
- Streaming wrap: with count=2, write and read every cycle for 10 cycles -> count stays 2, FIFO order preserved across pointer wrap, no overflow.
- Overflow: when full, pulse ena with item 0x55 -> item dropped, overflow=1 sticky, count=4, drain order unchanged.
- Corner cases:
  - With empty=1, read=1 and ena=1 with 0x66 -> count=1, item_out=0x66 next cycle.
  - With full, read=1 and ena=1 -> count=3, overflow=1.
